// File: rtl/cfg_seq_pkg.sv
// Shared types and helpers for the configuration chain sequencer.
// Holds the state enum, default sizes and the segment length field extractor.
package cfg_seq_pkg;

    localparam int NUM_SEG_DEF = 4;
    localparam int LEN_W_DEF   = 8;
    localparam int SEG_BUS_MAX = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SEG_END,
        DONE,
        ERR
    } state_e;

    // Extract the w-bit field i from a packed length bus (zero-extended bus).
    function automatic logic [31:0] seg_field(
        input logic [SEG_BUS_MAX-1:0] bus,
        input int                     i,
        input int                     w
    );
        return 32'(bus >> (i * w)) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/cfg_bit_counter.sv
// Load / increment / terminal-count counter.
// tc is high while the next increment would bring the count up to len.
module cfg_bit_counter
    import cfg_seq_pkg::*;
#(
    parameter int W = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] len,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] len_q;
    logic [W-1:0] len_d;

    // Load clears the count and captures the limit; inc steps the count.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (load) begin
            cnt_d = '0;
            len_d = len;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count and limit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign tc = ((cnt_q + W'(1)) == len_q);

endmodule

// File: rtl/cfg_chain_sequencer.sv
// Serial programmer for the emulator configuration chain segments.
// Optional stall timeout with ERR state when CFG_TIMEOUT_EN is defined.
module cfg_chain_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int NUM_SEG = NUM_SEG_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
`ifdef CFG_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_SEG*LEN_W-1:0] seg_len,
    input  logic                     bit_valid,
    input  logic                     bit_data,
    output logic                     bit_ready,
    output logic                     cfg_data,
    output logic [NUM_SEG-1:0]       cfg_shift_en,
    output logic [NUM_SEG-1:0]       seg_done,
    output logic                     prgm_b,
    output logic                     busy,
    output logic                     error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [NUM_SEG-1:0] seg_done_q;
    logic [NUM_SEG-1:0] seg_done_d;
    logic [NUM_SEG-1:0] shift_en_q;
    logic [NUM_SEG-1:0] shift_en_d;
    logic               cfg_data_q;
    logic               cfg_data_d;

    logic               hs;
    logic               load;
    logic               bit_tc;
    logic [LEN_W-1:0]   len_sel;

    assign len_sel   = LEN_W'(seg_field(SEG_BUS_MAX'(seg_len), int'(idx_q), LEN_W));
    assign load      = (state_q == LOAD);
    assign bit_ready = (state_q == SHIFT);
    assign hs        = bit_valid & bit_ready;

    // Bit counter: captured length in LOAD, stepped on every accepted bit.
    cfg_bit_counter #(
        .W(LEN_W)
    ) u_bit_cnt (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .inc  (hs),
        .len  (len_sel),
        .tc   (bit_tc)
    );

`ifdef CFG_TIMEOUT_EN
    logic stall_inc;
    logic stall_tc;

    assign stall_inc = bit_ready & ~bit_valid;

    // Stall counter: restarted on SHIFT entry and on each handshake.
    cfg_bit_counter #(
        .W(LEN_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .load (load | hs),
        .inc  (stall_inc),
        .len  (LEN_W'(TIMEOUT)),
        .tc   (stall_tc)
    );

    assign error = (state_q == ERR);
`else
    assign error = 1'b0;
`endif

    // Next-state, segment index, done flags and serial output staging.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seg_done_d = seg_done_q;
        cfg_data_d = cfg_data_q;
        shift_en_d = '0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LOAD;
                    idx_d      = '0;
                    seg_done_d = '0;
                end
            end
            LOAD: begin
                state_d = (len_sel == '0) ? SEG_END : SHIFT;
            end
            SHIFT: begin
                if (hs) begin
                    cfg_data_d = bit_data;
                    shift_en_d = NUM_SEG'(1) << idx_q;
                    if (bit_tc) begin
                        state_d = SEG_END;
                    end
                end
`ifdef CFG_TIMEOUT_EN
                else if (stall_inc && stall_tc) begin
                    state_d = ERR;
                end
`endif
            end
            SEG_END: begin
                seg_done_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            seg_done_q <= '0;
            shift_en_q <= '0;
            cfg_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seg_done_q <= seg_done_d;
            shift_en_q <= shift_en_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign cfg_data     = cfg_data_q;
    assign cfg_shift_en = shift_en_q;
    assign seg_done     = seg_done_q;
    assign prgm_b       = (state_q == DONE);
    assign busy         = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_cfg_chain_sequencer.sv
// Randomised self-checking bench for cfg_chain_sequencer.
// Expected waveforms come from a per-pass schedule built from segment lengths.
module tb_cfg_chain_sequencer;

    localparam int NS   = 4;
    localparam int LW   = 8;
    localparam int MAXC = 512;

    typedef logic [NS*LW-1:0] seg_bus_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    seg_bus_t      seg_len;
    logic          bit_valid;
    logic          bit_data;
    logic          bit_ready;
    logic          cfg_data;
    logic [NS-1:0] cfg_shift_en;
    logic [NS-1:0] seg_done;
    logic          prgm_b;
    logic          busy;
    logic          error;

    int checks   = 0;
    int failures = 0;

`ifdef CFG_TIMEOUT_EN
    cfg_chain_sequencer #(
        .NUM_SEG(NS),
        .LEN_W  (LW),
        .TIMEOUT(10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seg_len     (seg_len),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .bit_ready   (bit_ready),
        .cfg_data    (cfg_data),
        .cfg_shift_en(cfg_shift_en),
        .seg_done    (seg_done),
        .prgm_b      (prgm_b),
        .busy        (busy),
        .error       (error)
    );
`else
    cfg_chain_sequencer #(
        .NUM_SEG(NS),
        .LEN_W  (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seg_len     (seg_len),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .bit_ready   (bit_ready),
        .cfg_data    (cfg_data),
        .cfg_shift_en(cfg_shift_en),
        .seg_done    (seg_done),
        .prgm_b      (prgm_b),
        .busy        (busy),
        .error       (error)
    );
`endif

    always #5 clk = ~clk;

    bit            vpat[MAXC];
    bit            dpat[MAXC];
    bit            spat[MAXC];
    bit            ld[MAXC];
    bit            x_ready[MAXC];
    bit            x_data[MAXC];
    logic [NS-1:0] x_en[MAXC];
    logic [NS-1:0] x_done[MAXC];
    int            lens[NS];
    int            done_cyc;

    logic          prev_prgm;
    logic          prev_busy;
    logic          prev_err;
    logic [NS-1:0] prev_done;

    logic          chk_en  = 1'b0;
    logic          chk_dat = 1'b0;
    logic          e_ready;
    logic          e_data;
    logic          e_prgm;
    logic          e_busy;
    logic          e_err;
    logic [NS-1:0] e_en;
    logic [NS-1:0] e_done;

    int cur_c;
    int pulses;
    int rise_c;
    int seg_pulses[NS];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // Per-cycle comparison against the schedule-derived expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bit_ready", 32'(bit_ready), 32'(e_ready));
            chk("cfg_shift_en", 32'(cfg_shift_en), 32'(e_en));
            if (chk_dat) chk("cfg_data", 32'(cfg_data), 32'(e_data));
            chk("seg_done", 32'(seg_done), 32'(e_done));
            chk("prgm_b", 32'(prgm_b), 32'(e_prgm));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("error", 32'(error), 32'(e_err));
            if (cfg_shift_en != '0) pulses++;
            for (int i = 0; i < NS; i++) seg_pulses[i] += int'(cfg_shift_en[i]);
            if (prgm_b && rise_c < 0 && cur_c > 0) rise_c = cur_c;
        end
    end

    function automatic seg_bus_t pack_lens();
        seg_bus_t p;
        for (int s = 0; s < NS; s++) p[s*LW +: LW] = LW'(lens[s]);
        return p;
    endfunction

    // Cycle 0 carries start; cycle 1 is the first LOAD. Each segment costs
    // one LOAD, one cycle per offered slot until len bits taken, one SEG_END.
    task automatic build_sched();
        int c;
        int acc;
        int seg_end[NS];
        for (int k = 0; k < MAXC; k++) begin
            x_ready[k] = 0;
            x_data[k]  = 0;
            x_en[k]    = '0;
            x_done[k]  = '0;
            ld[k]      = 0;
        end
        c = 1;
        for (int s = 0; s < NS; s++) begin
            ld[c] = 1;
            c++;
            acc = 0;
            while (acc < lens[s] && c < MAXC - 8) begin
                x_ready[c] = 1;
                if (vpat[c]) begin
                    acc++;
                    x_en[c+1]   = NS'(1) << s;
                    x_data[c+1] = dpat[c];
                end
                c++;
            end
            seg_end[s] = c;
            c++;
        end
        done_cyc = c;
        for (int k = 0; k < MAXC; k++)
            for (int s = 0; s < NS; s++)
                if (k > seg_end[s]) x_done[k][s] = 1'b1;
    endtask

    task automatic gen_stim(input bit full);
        int z;
        z = 0;
        for (int c = 0; c < MAXC; c++) begin
            dpat[c] = 1'($urandom_range(0, 1));
            if (full || c >= 300) begin
                vpat[c] = 1;
            end else begin
                vpat[c] = ($urandom_range(0, 2) != 0);
                z = vpat[c] ? 0 : z + 1;
                if (z > 4) begin
                    vpat[c] = 1;
                    z = 0;
                end
            end
        end
    endtask

    task automatic set_spat(input bit noisy);
        for (int c = 0; c < MAXC; c++)
            spat[c] = (c == 0) ||
                      (noisy && c < done_cyc && $urandom_range(0, 5) == 0);
    endtask

    task automatic run_pass(input int ncyc);
        pulses = 0;
        rise_c = -1;
        for (int i = 0; i < NS; i++) seg_pulses[i] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cur_c     = c;
            start     = spat[c];
            bit_valid = vpat[c];
            bit_data  = dpat[c];
            seg_len   = ld[c] ? pack_lens() : seg_bus_t'($urandom());
            if (c == 0) begin
                e_ready = 1'b0;
                e_en    = '0;
                e_data  = 1'b0;
                chk_dat = 1'b0;
                e_prgm  = prev_prgm;
                e_busy  = prev_busy;
                e_err   = prev_err;
                e_done  = prev_done;
            end else begin
                e_ready = x_ready[c];
                e_en    = x_en[c];
                e_data  = x_data[c];
                chk_dat = (x_en[c] != '0);
                e_prgm  = (c >= done_cyc);
                e_busy  = (c < done_cyc);
                e_err   = 1'b0;
                e_done  = x_done[c];
            end
            chk_en = 1'b1;
        end
        if (ncyc > done_cyc) begin
            prev_prgm = 1'b1;
            prev_busy = 1'b0;
            prev_err  = 1'b0;
            prev_done = '1;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 32'(bit_ready), 32'd0);
        chk({nm, "_shift_en"}, 32'(cfg_shift_en), 32'd0);
        chk({nm, "_data"}, 32'(cfg_data), 32'd0);
        chk({nm, "_done"}, 32'(seg_done), 32'd0);
        chk({nm, "_prgm_b"}, 32'(prgm_b), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        seg_len   = '0;
        prev_prgm = 1'b0;
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        prev_done = '0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic pass: {3,5,2,4}, valid held, alternating data, start in SHIFT.
        lens = '{3, 5, 2, 4};
        gen_stim(1'b1);
        for (int c = 0; c < MAXC; c++) dpat[c] = bit'(c % 2);
        build_sched();
        chk("model_basic_done_cyc", 32'(done_cyc), 32'd23);
        set_spat(1'b0);
        spat[3] = 1;
        run_pass(done_cyc + 3);
        @(negedge clk);
        #1;
        chk("basic_pulses", 32'(pulses), 32'd14);
        chk("basic_rise", 32'(rise_c), 32'd23);
        chk("basic_seg1_pulses", 32'(seg_pulses[1]), 32'd5);
        chk("basic_seg_done", 32'(seg_done), 32'hF);

        // Zero-length segment, started from DONE.
        lens = '{3, 0, 2, 4};
        gen_stim(1'b1);
        build_sched();
        chk("model_zero_done_cyc", 32'(done_cyc), 32'd18);
        set_spat(1'b0);
        run_pass(done_cyc + 2);
        @(negedge clk);
        #1;
        chk("zero_pulses", 32'(pulses), 32'd9);
        chk("zero_seg1_pulses", 32'(seg_pulses[1]), 32'd0);
        chk("zero_rise", 32'(rise_c), 32'd18);

        // Backpressure: valid toggles every cycle.
        lens = '{3, 5, 2, 4};
        gen_stim(1'b1);
        for (int c = 0; c < 300; c++) vpat[c] = bit'(c % 2);
        build_sched();
        set_spat(1'b0);
        run_pass(done_cyc + 2);
        @(negedge clk);
        #1;
        chk("bp_pulses", 32'(pulses), 32'd14);

        // Full-scale segment length must not wrap.
        lens = '{255, 1, 0, 2};
        gen_stim(1'b1);
        build_sched();
        set_spat(1'b1);
        run_pass(done_cyc + 2);
        @(negedge clk);
        #1;
        chk("full_seg0_pulses", 32'(seg_pulses[0]), 32'd255);

        // Randomised passes with noisy start and random gaps.
        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < NS; s++) lens[s] = $urandom_range(0, 12);
            gen_stim(1'b0);
            build_sched();
            set_spat(1'b1);
            run_pass(done_cyc + $urandom_range(1, 4));
        end

        // Mid-pass reset during segment 2 SHIFT.
        lens = '{4, 4, 6, 4};
        gen_stim(1'b1);
        build_sched();
        set_spat(1'b0);
        run_pass(16);
        #2;
        reset  = 1'b1;
        chk_en = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset     = 1'b0;
        start     = 1'b0;
        prev_prgm = 1'b0;
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        prev_done = '0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_busy", 32'(busy), 32'd0);
            chk("post_reset_prgm", 32'(prgm_b), 32'd0);
        end
        gen_stim(1'b0);
        build_sched();
        set_spat(1'b0);
        run_pass(done_cyc + 2);
        @(negedge clk);
        #1;
        chk("restart_pulses", 32'(pulses), 32'd18);

`ifdef CFG_TIMEOUT_EN
        // Stall timeout: two bits accepted, then valid held low.
        chk_en = 1'b0;
        lens   = '{3, 5, 2, 4};
        for (int c = 0; c < 17; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0);
            bit_valid = (c == 2 || c == 3);
            bit_data  = 1'b1;
            seg_len   = pack_lens();
            @(negedge clk);
            if (c == 13) begin
                chk("to_err_before", 32'(error), 32'd0);
                chk("to_ready_before", 32'(bit_ready), 32'd1);
            end
            if (c == 14) begin
                chk("to_err", 32'(error), 32'd1);
                chk("to_ready", 32'(bit_ready), 32'd0);
                chk("to_prgm", 32'(prgm_b), 32'd0);
            end
            if (c == 16) chk("to_err_sticky", 32'(error), 32'd1);
        end
        prev_prgm = 1'b0;
        prev_busy = 1'b1;
        prev_err  = 1'b1;
        prev_done = '0;
        gen_stim(1'b0);
        build_sched();
        set_spat(1'b0);
        run_pass(done_cyc + 2);
        @(negedge clk);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
